// File: rtl/abacus_window_controller.sv
// rtl/abacus_window_controller.sv - profiling window sequencer with register port
// Optional cycle timestamp of each window start: define ABACUS_WINDOW_TIMESTAMP_EN.
module abacus_window_controller #(
  parameter int WINDOW_WIDTH       = 32,
  parameter int DEFAULT_WINDOW_LEN = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [31:0]             cfg_wdata,
  output logic [31:0]             cfg_rdata,
  input  logic                    trigger_in,
  output logic                    profile_enable,
  output logic                    counter_clear,
  output logic                    window_done_irq,
  output logic [WINDOW_WIDTH-1:0] cycles_elapsed
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state;
  logic [WINDOW_WIDTH-1:0] window_len;
  logic [WINDOW_WIDTH-1:0] len_q;
  logic                    auto_rearm;
  logic                    trig_mode;
  logic                    done_sticky;
  logic                    aborted;
  logic                    len_err;
  logic [31:0]             window_count;

  logic ctrl_wr;
  logic start_req;
  logic stop_req;
  logic done_w1c;
  logic run_last;
  logic rearm;

  // STOP in the same CTRL write suppresses START.
  assign ctrl_wr   = cfg_we && (cfg_addr == 3'd0);
  assign stop_req  = ctrl_wr && cfg_wdata[1];
  assign start_req = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign done_w1c  = cfg_we && (cfg_addr == 3'd2) && cfg_wdata[3];
  // A zero length latched via ARMED ends the window after one cycle rather than wrapping.
  assign run_last  = (cycles_elapsed == len_q - WINDOW_WIDTH'(1)) || (len_q == '0);
  assign rearm     = auto_rearm && !aborted && !stop_req;

  assign window_done_irq = done_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      window_len     <= WINDOW_WIDTH'(DEFAULT_WINDOW_LEN);
      len_q          <= '0;
      auto_rearm     <= 1'b0;
      trig_mode      <= 1'b0;
      done_sticky    <= 1'b0;
      aborted        <= 1'b0;
      len_err        <= 1'b0;
      window_count   <= '0;
      cycles_elapsed <= '0;
      profile_enable <= 1'b0;
      counter_clear  <= 1'b0;
    end else begin
      counter_clear  <= 1'b0;
      profile_enable <= 1'b0;
      if (ctrl_wr) begin
        auto_rearm <= cfg_wdata[2];
        trig_mode  <= cfg_wdata[3];
      end
      if (cfg_we && (cfg_addr == 3'd1)) window_len <= WINDOW_WIDTH'(cfg_wdata);
      if (done_w1c) done_sticky <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req) begin
            if (window_len == '0) begin
              len_err <= 1'b1;
            end else begin
              aborted <= 1'b0;
              len_err <= 1'b0;
              if (cfg_wdata[3]) begin
                state <= S_ARMED;
              end else begin
                state         <= S_CLEAR;
                counter_clear <= 1'b1;
              end
            end
          end
        end
        S_ARMED: begin
          if (stop_req) begin
            state <= S_IDLE;
          end else if (trigger_in) begin
            state         <= S_CLEAR;
            counter_clear <= 1'b1;
          end
        end
        S_CLEAR: begin
          len_q          <= window_len;
          cycles_elapsed <= '0;
          profile_enable <= 1'b1;
          state          <= S_RUN;
        end
        S_RUN: begin
          if (stop_req || run_last) begin
            state       <= S_DONE;
            done_sticky <= 1'b1;
            if (window_count != '1) window_count <= window_count + 32'd1;
            if (stop_req) aborted <= 1'b1;
          end else begin
            cycles_elapsed <= cycles_elapsed + WINDOW_WIDTH'(1);
            profile_enable <= 1'b1;
          end
        end
        S_DONE: begin
          if (rearm && (window_len != '0)) begin
            if (trig_mode) begin
              state <= S_ARMED;
            end else begin
              state         <= S_CLEAR;
              counter_clear <= 1'b1;
            end
          end else begin
            if (rearm) len_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ABACUS_WINDOW_TIMESTAMP_EN
  logic [31:0] ts_free;
  logic [31:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_free <= '0;
      ts_q    <= '0;
    end else begin
      ts_free <= ts_free + 32'd1;
      if (state == S_CLEAR) ts_q <= ts_free;
    end
  end
`endif

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0: cfg_rdata = {28'd0, trig_mode, auto_rearm, 2'b00};
      3'd1: cfg_rdata = 32'(window_len);
      3'd2: cfg_rdata = {26'd0, len_err, aborted, done_sticky, state};
      3'd3: cfg_rdata = window_count;
`ifdef ABACUS_WINDOW_TIMESTAMP_EN
      3'd4: cfg_rdata = ts_q;
`endif
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_abacus_window_controller.sv
// tb/tb_abacus_window_controller.sv - self-checking bench for abacus_window_controller
module tb_abacus_window_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        trigger_in;
  logic        profile_enable;
  logic        counter_clear;
  logic        window_done_irq;
  logic [31:0] cycles_elapsed;

  abacus_window_controller #(
    .WINDOW_WIDTH(32),
    .DEFAULT_WINDOW_LEN(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .trigger_in(trigger_in),
    .profile_enable(profile_enable),
    .counter_clear(counter_clear),
    .window_done_irq(window_done_irq),
    .cycles_elapsed(cycles_elapsed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cc_total = 0;
  int pe_total = 0;

  always @(negedge clk) begin
    cc_total <= cc_total + int'(counter_clear);
    pe_total <= pe_total + int'(profile_enable);
  end

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  logic [31:0] d;
  int cc0, pe0, bad, exp_count;

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    trigger_in = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset state
    check("rst_pe", {31'd0, profile_enable}, 32'd0);
    check("rst_cc", {31'd0, counter_clear}, 32'd0);
    check("rst_irq", {31'd0, window_done_irq}, 32'd0);
    check("rst_elapsed", cycles_elapsed, 32'd0);
    rd(3'd0, d); check("rst_ctrl", d, 32'd0);
    rd(3'd1, d); check("rst_len", d, 32'd1000);
    rd(3'd2, d); check("rst_status", d, 32'd0);
    rd(3'd3, d); check("rst_count", d, 32'd0);

    // Register-port table
    vecs[0]  = '{1'b1, 3'd1, 32'd5,        3'd1, 32'd5,        "len_rw"};
    vecs[1]  = '{1'b1, 3'd0, 32'hC,        3'd0, 32'hC,        "ctrl_rw"};
    vecs[2]  = '{1'b1, 3'd0, 32'hF,        3'd2, 32'd0,        "start_stop_same"};
    vecs[3]  = '{1'b0, 3'd0, 32'd0,        3'd0, 32'hC,        "ctrl_pulses_read0"};
    vecs[4]  = '{1'b1, 3'd0, 32'd0,        3'd0, 32'd0,        "ctrl_clear"};
    vecs[5]  = '{1'b1, 3'd3, 32'd7,        3'd3, 32'd0,        "count_ro"};
    vecs[6]  = '{1'b1, 3'd5, 32'hFF,       3'd5, 32'd0,        "addr5"};
    vecs[7]  = '{1'b1, 3'd7, 32'd1,        3'd7, 32'd0,        "addr7"};
    vecs[8]  = '{1'b0, 3'd0, 32'd0,        3'd6, 32'd0,        "addr6"};
    vecs[9]  = '{1'b1, 3'd2, 32'h3F,       3'd2, 32'd0,        "status_ro"};
    vecs[10] = '{1'b1, 3'd1, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, "len_max"};
    cc0 = cc_total;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      else step(1);
      rd(vecs[i].raddr, d);
      check(vecs[i].name, d, vecs[i].exp);
    end
    step(1);
    check("table_no_clear", cc_total - cc0, 32'd0);
`ifndef ABACUS_WINDOW_TIMESTAMP_EN
    rd(3'd4, d); check("ts_absent", d, 32'd0);
`endif

    // Immediate window of 5
    wr(3'd1, 32'd5);
    cc0 = cc_total; pe0 = pe_total;
    wr(3'd0, 32'h1);
    check("lat_cc", {31'd0, counter_clear}, 32'd1);
    check("lat_pe_off", {31'd0, profile_enable}, 32'd0);
    step(1);
    check("lat_pe_on", {31'd0, profile_enable}, 32'd1);
    step(10);
    check("w5_cc_cnt", cc_total - cc0, 32'd1);
    check("w5_pe_cnt", pe_total - pe0, 32'd5);
    check("w5_elapsed", cycles_elapsed, 32'd4);
    rd(3'd2, d); check("w5_status", d, 32'h8);
    check("w5_irq", {31'd0, window_done_irq}, 32'd1);
    rd(3'd3, d); check("w5_count", d, 32'd1);
    wr(3'd2, 32'h8);
    check("w1c_irq", {31'd0, window_done_irq}, 32'd0);

`ifdef ABACUS_WINDOW_TIMESTAMP_EN
    rd(3'd4, d); check("ts_present", {31'd0, d != 32'd0}, 32'd1);
`endif

    // Triggered window
    cc0 = cc_total; pe0 = pe_total;
    wr(3'd0, 32'h9);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      rd(3'd2, d);
      if (d[2:0] != 3'd1) bad++;
      step(1);
    end
    check("armed_state", bad, 32'd0);
    check("armed_no_pe", pe_total - pe0, 32'd0);
    check("armed_no_cc", cc_total - cc0, 32'd0);
    pe0 = pe_total;
    trigger_in = 1'b1;
    step(1);
    trigger_in = 1'b0;
    check("trig_cc", {31'd0, counter_clear}, 32'd1);
    step(1);
    check("trig_pe", {31'd0, profile_enable}, 32'd1);
    step(8);
    check("trig_pe_cnt", pe_total - pe0, 32'd5);
    wr(3'd2, 32'h8);

    // Abort at RUN cycle 20 with AUTO_REARM set
    wr(3'd1, 32'd100);
    pe0 = pe_total;
    wr(3'd0, 32'h5);
    step(21);
    check("abort_pe_before", {31'd0, profile_enable}, 32'd1);
    wr(3'd0, 32'h6);
    check("abort_pe_drop", {31'd0, profile_enable}, 32'd0);
    step(5);
    rd(3'd2, d); check("abort_status", d, 32'h18);
    check("abort_elapsed", cycles_elapsed, 32'd20);
    check("abort_pe_cnt", pe_total - pe0, 32'd21);
    rd(3'd3, d); check("abort_count", d, 32'd3);

    // Zero length
    wr(3'd2, 32'h8);
    wr(3'd1, 32'd0);
    cc0 = cc_total;
    wr(3'd0, 32'h1);
    step(3);
    rd(3'd2, d); check("len0_status", d & 32'h27, 32'h20);
    check("len0_no_cc", cc_total - cc0, 32'd0);

    // Asynchronous reset mid-RUN
    wr(3'd1, 32'd50);
    wr(3'd0, 32'h1);
    step(10);
    check("rst_mid_pe_before", {31'd0, profile_enable}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_pe", {31'd0, profile_enable}, 32'd0);
    rd(3'd2, d); check("rst_mid_status", d, 32'd0);
    rd(3'd3, d); check("rst_mid_count", d, 32'd0);
    rd(3'd1, d); check("rst_mid_len", d, 32'd1000);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Auto-rearm: three back-to-back windows of 3, then ignored count write and STOP
    wr(3'd1, 32'd3);
    cc0 = cc_total; pe0 = pe_total;
    wr(3'd0, 32'h5);
    step(13);
    wr(3'd3, 32'd7);
    wr(3'd0, 32'h2);
    step(4);
    rd(3'd3, d); check("rearm_count", d, 32'd3);
    check("rearm_cc_cnt", cc_total - cc0, 32'd3);
    check("rearm_pe_cnt", pe_total - pe0, 32'd9);
    rd(3'd2, d); check("rearm_status", d, 32'h8);

    // Randomized windows against a count-based reference model
    exp_count = 3;
    for (int it = 0; it < 8; it++) begin
      int len, stop_at, exp_pe, exp_el;
      bit abort;
      len     = int'($urandom_range(1, 12));
      abort   = bit'($urandom_range(0, 1));
      stop_at = int'($urandom_range(0, len - 1));
      wr(3'd2, 32'h8);
      wr(3'd1, 32'(len));
      cc0 = cc_total; pe0 = pe_total;
      wr(3'd0, 32'h1);
      if (abort) begin
        step(1 + stop_at);
        wr(3'd0, 32'h2);
      end
      step(len + 4);
      exp_count++;
      exp_pe = abort ? stop_at + 1 : len;
      exp_el = abort ? stop_at : len - 1;
      check("rnd_pe_cnt", pe_total - pe0, 32'(exp_pe));
      check("rnd_cc_cnt", cc_total - cc0, 32'd1);
      check("rnd_elapsed", cycles_elapsed, 32'(exp_el));
      rd(3'd2, d); check("rnd_status", d, abort ? 32'h18 : 32'h8);
      rd(3'd3, d); check("rnd_count", d, 32'(exp_count));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abacus_window_controller.md
Name: abacus_window_controller

Overview:
- Sequences profiling windows for the ABACUS instruction and cache profilers.
- Drives their enable so it is asserted for exactly WINDOW_LEN cycles.
- Issues a one-cycle counter-clear pulse before each window and flags completion.
- Configured through a small decoded register port driven by the bus interface logic in the ABACUS top level.

Parameters:
- WINDOW_WIDTH, 32: width of window-length register and cycle counter.
- DEFAULT_WINDOW_LEN, 1000: reset value of WINDOW_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_we  in  1  register write strobe, one cycle per write.
- cfg_addr  in  3  register word index.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data; combinational from cfg_addr.
- trigger_in  in  1  external start trigger, sampled in ARMED.
- profile_enable  out  1  drives the profilers' enable inputs.
- counter_clear  out  1  one-cycle pulse; profilers zero their counters.
- window_done_irq  out  1  level; equals the DONE_STICKY status bit.
- cycles_elapsed  out  WINDOW_WIDTH  live cycle count of the current or last window.

Behaviour:
- Register map:
  - 0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 STOP (write-1 pulse, reads 0); bit2 AUTO_REARM; bit3 TRIG_MODE (0 immediate, 1 wait trigger_in).
  - 1 WINDOW_LEN.
  - 2 STATUS: [2:0] state; bit3 DONE_STICKY (write-1-to-clear); bit4 ABORTED; bit5 LEN_ERR.
  - 3 WINDOW_COUNT: read-only, saturates at all-ones.
  - 4 TIMESTAMP (see Optional Feature).
  - 5–7 read 0, writes ignored.
- Reset values:
  - state IDLE; all outputs 0.
  - WINDOW_LEN = DEFAULT_WINDOW_LEN.
  - CTRL bits, STATUS bits and WINDOW_COUNT all 0.
- State encoding: IDLE=0, ARMED=1, CLEAR=2, RUN=3, DONE=4.
- IDLE:
  - START with WINDOW_LEN=0: set LEN_ERR, stay in IDLE.
  - Otherwise: clear ABORTED and LEN_ERR; go to CLEAR (TRIG_MODE=0) or ARMED (TRIG_MODE=1).
- ARMED:
  - trigger_in=1 → CLEAR.
  - STOP → IDLE, without setting ABORTED.
- CLEAR (1 cycle):
  - counter_clear=1; latch WINDOW_LEN into len_q; cycles_elapsed←0 → RUN.
- RUN:
  - profile_enable=1; cycles_elapsed increments every cycle.
  - When cycles_elapsed==len_q-1 → DONE; profile_enable is high for exactly len_q cycles.
  - STOP → DONE with ABORTED=1; profile_enable drops the next cycle.
- DONE (1 cycle):
  - Set DONE_STICKY; WINDOW_COUNT+1 (saturating).
  - AUTO_REARM=1 and not ABORTED → CLEAR/ARMED per TRIG_MODE; else → IDLE.
  - cycles_elapsed holds its final value until the next CLEAR.
- Latency: START write at cycle t gives counter_clear at t+1 and profile_enable at t+2 (immediate mode).
- Simultaneous-event rules:
  - START and STOP in the same write: STOP wins, START ignored.
  - START outside IDLE: ignored.
  - W1C of DONE_STICKY in the same cycle as DONE entry: set wins.
  - WINDOW_LEN write during RUN: takes effect at the next CLEAR only.
- Async rst mid-window: profile_enable drops immediately; state → IDLE.

Optional Feature:
- Macro: ABACUS_WINDOW_TIMESTAMP_EN.
- When defined:
  - Free-running 32-bit cycle timestamp, wraps at all-ones, reset 0.
  - Captured into TIMESTAMP (addr 4) in CLEAR, marking the start of each window.
- When undefined: addr 4 reads 0 and no timestamp logic is built.

Test Plan:
- WINDOW_LEN=5, START (TRIG_MODE=0):
  - counter_clear pulses 1 cycle, then profile_enable high exactly 5 cycles.
  - cycles_elapsed ends at 4; DONE_STICKY=1, irq=1, WINDOW_COUNT=1, state returns to 0.
- TRIG_MODE=1, START, trigger_in held low 10 cycles then pulsed:
  - state reads 1 throughout the wait; enable stays 0.
  - counter_clear 1 cycle after the trigger; enable follows for WINDOW_LEN cycles.
- WINDOW_LEN=100, START, STOP at RUN cycle 20:
  - profile_enable drops next cycle; ABORTED=1, DONE_STICKY=1, cycles_elapsed=20.
  - Returns to IDLE even with AUTO_REARM=1.
- WINDOW_LEN=0, START:
  - LEN_ERR=1, state stays 0, no counter_clear pulse.
- AUTO_REARM=1, WINDOW_LEN=3, START, run 3 windows, then write WINDOW_COUNT=7 (ignored) and STOP:
  - Back-to-back CLEAR/RUN sequences; WINDOW_COUNT reads 3 after STOP.
- Assert rst asynchronously mid-RUN:
  - profile_enable 0 before the next clk edge; all STATUS bits and WINDOW_COUNT read 0.
  - WINDOW_LEN reads DEFAULT_WINDOW_LEN.
